// File: rtl/ssd_pkg.sv
// ssd_pkg: shared constants for the seven-segment scan driver.
//   - SEG_0..SEG_9, SEG_BLANK: active-low patterns {a,b,c,d,e,f,g,dp}, dp bit = 1
//   - set_mode_e: set-mode codes (run, minute-set, hour-set, idle)
//   - DIGIT_EN: active-low one-hot digit enables, DIGIT_EN[n] lights digit n
package ssd_pkg;

   localparam logic [7:0] SEG_0     = 8'b0000_0011;
   localparam logic [7:0] SEG_1     = 8'b1001_1111;
   localparam logic [7:0] SEG_2     = 8'b0010_0101;
   localparam logic [7:0] SEG_3     = 8'b0000_1101;
   localparam logic [7:0] SEG_4     = 8'b1001_1001;
   localparam logic [7:0] SEG_5     = 8'b0100_1001;
   localparam logic [7:0] SEG_6     = 8'b0100_0001;
   localparam logic [7:0] SEG_7     = 8'b0001_1111;
   localparam logic [7:0] SEG_8     = 8'b0000_0001;
   localparam logic [7:0] SEG_9     = 8'b0000_1001;
   localparam logic [7:0] SEG_BLANK = 8'b1111_1111;

   typedef enum logic [1:0] {
      SET_RUN  = 2'b00,
      SET_MIN  = 2'b01,
      SET_HOUR = 2'b10,
      SET_IDLE = 2'b11
   } set_mode_e;

   localparam logic [3:0][3:0] DIGIT_EN = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

endpackage

// File: rtl/bcd_to_seg.sv
// bcd_to_seg: combinational BCD to seven-segment decoder.
//   bcd [3:0] in  : digit value; 10..15 decode to blank
//   seg [6:0] out : active-low segments {a,b,c,d,e,f,g}
module bcd_to_seg
   import ssd_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK[7:1];
      case (bcd)
         4'd0: seg = SEG_0[7:1];
         4'd1: seg = SEG_1[7:1];
         4'd2: seg = SEG_2[7:1];
         4'd3: seg = SEG_3[7:1];
         4'd4: seg = SEG_4[7:1];
         4'd5: seg = SEG_5[7:1];
         4'd6: seg = SEG_6[7:1];
         4'd7: seg = SEG_7[7:1];
         4'd8: seg = SEG_8[7:1];
         4'd9: seg = SEG_9[7:1];
         default: seg = SEG_BLANK[7:1];
      endcase
   end

endmodule

// File: rtl/ssd_scan.sv
// ssd_scan: four-digit multiplexed seven-segment scan driver (HH.MM).
//   clk, rst       : system clock, synchronous active-high reset
//   in0..in3 [3:0] : BCD digits, in0 = minutes units (rightmost)
//   set [1:0]      : 00 run, 01 minute-set, 10 hour-set, 11 idle
//   ssd_ctl [3:0]  : active-low digit enables, bit n = digit n (registered)
//   ssd_seg [7:0]  : active-low segments {a..g,dp} (registered)
// All four digits are snapshotted together at each frame end so a mid-frame
// roll-over never shows torn values. Define SSD_SCAN_BLINK_EN to blink the
// field being edited in set mode; otherwise set and BLINK_FRAMES are ignored.
module ssd_scan
   import ssd_pkg::*;
#(
   parameter int unsigned SCAN_DIV     = 50000,
   parameter int unsigned BLINK_FRAMES = 64
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] in0,
   input  logic [3:0] in1,
   input  logic [3:0] in2,
   input  logic [3:0] in3,
   input  logic [1:0] set,
   output logic [3:0] ssd_ctl,
   output logic [7:0] ssd_seg
);

   localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

   logic [CW-1:0] cnt;
   logic [1:0]    idx;
   logic [3:0]    sh0, sh1, sh2, sh3;
   logic          digit_end;
   logic          frame_end;
   logic [3:0]    cur;
   logic [6:0]    seg7;
   logic          blank;

   assign digit_end = (cnt == CNT_LAST);
   assign frame_end = digit_end && (idx == 2'd3);

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
         idx <= '0;
         sh0 <= '0;
         sh1 <= '0;
         sh2 <= '0;
         sh3 <= '0;
      end else begin
         if (digit_end) begin
            cnt <= '0;
            idx <= idx + 2'd1;
         end else begin
            cnt <= cnt + CW'(1);
         end
         if (frame_end) begin
            sh0 <= in0;
            sh1 <= in1;
            sh2 <= in2;
            sh3 <= in3;
         end
      end
   end

`ifdef SSD_SCAN_BLINK_EN
   localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [FW-1:0] FCNT_LAST = FW'(BLINK_FRAMES - 1);

   logic [FW-1:0] fcnt;
   logic          blink_off;
   set_mode_e     set_sh;

   // set_sh is captured with the digits so mode and values change together.
   always_ff @(posedge clk) begin
      if (rst) begin
         fcnt      <= '0;
         blink_off <= 1'b0;
         set_sh    <= SET_RUN;
      end else if (frame_end) begin
         set_sh <= set_mode_e'(set);
         if (fcnt == FCNT_LAST) begin
            fcnt      <= '0;
            blink_off <= ~blink_off;
         end else begin
            fcnt <= fcnt + FW'(1);
         end
      end
   end

   // idx[1] selects the hours pair (digits 2,3), otherwise the minutes pair.
   always_comb begin
      blank = 1'b0;
      if (blink_off) begin
         if (set_sh == SET_MIN)  blank = ~idx[1];
         if (set_sh == SET_HOUR) blank = idx[1];
      end
   end
`else
   logic [31:0] unused_cfg;
   assign unused_cfg = {30'(BLINK_FRAMES), set};
   assign blank      = 1'b0;
`endif

   always_comb begin
      cur = '0;
      case (idx)
         2'd0: cur = sh0;
         2'd1: cur = sh1;
         2'd2: cur = sh2;
         2'd3: cur = sh3;
         default: cur = '0;
      endcase
   end

   bcd_to_seg u_dec (
      .bcd (cur),
      .seg (seg7)
   );

   // Blanking only affects a..g; the HH.MM separator stays lit on digit 2.
   always_ff @(posedge clk) begin
      if (rst) begin
         ssd_ctl <= 4'b1111;
         ssd_seg <= '1;
      end else begin
         ssd_ctl <= DIGIT_EN[idx];
         ssd_seg <= {(blank ? 7'h7F : seg7), (idx != 2'd2)};
      end
   end

endmodule
